ibuffer_rr_issue: RTL

Parametrised multi-warp instruction buffer with an integrated round-robin issue arbiter. It sits between the decode stage and the operand collector.
- Each warp gets a `DEPTH`-entry circular FIFO, filled by `NUM_DECODE` decode slots per cycle.
- It arbitrates issue internally (no external IU grant), flushes per warp on SIMT drop, and sequences warp exit once the scoreboard drains.

---
 rtl/ibuffer_pkg.sv | 25 ++
 rtl/ibuffer_warp_fifo.sv | 85 ++++++++
 rtl/ibuffer_rr_issue.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ibuffer_pkg.sv
// ibuffer_pkg: shared constants and types for the instruction buffer.
//   - BUNDLE_W_DEF : default width of a decoded-instruction bundle
//   - OFF_*        : bit offsets of fields inside the packed bundle
//   - ib_entry_t   : stored FIFO entry {exit, bundle}; exit sits in the MSB
package ibuffer_pkg;

    localparam int BUNDLE_W_DEF = 64;

    // Field offsets inside the decoded bundle (LSB positions)
    localparam int OFF_SRC1   = 0;
    localparam int OFF_SRC2   = 6;
    localparam int OFF_DST    = 12;
    localparam int OFF_VALIDS = 18;
    localparam int OFF_IMM    = 21;
    localparam int OFF_ALUOP  = 37;
    localparam int OFF_MEM    = 43;
    localparam int OFF_BRANCH = 47;
    localparam int OFF_SCBID  = 50;

    typedef struct packed {
        logic                    exit;
        logic [BUNDLE_W_DEF-1:0] bundle;
    } ib_entry_t;

endpackage

// File: rtl/ibuffer_warp_fifo.sv
// ibuffer_warp_fifo: one warp's circular instruction FIFO.
//   clk, rst        : clock, async active-low reset
//   i_wr_en/data    : NUM_DECODE masked write ports, slot 0 first
//   i_pop           : pop head (caller guarantees non-empty)
//   i_clear         : warp exit; drop everything, including same-cycle writes
//   i_flush         : SIMT drop; same effect as clear
//   o_head          : head entry {exit, bundle}
//   o_count/o_empty : occupancy
//   o_ovf           : pulse when a write was dropped because the FIFO was full
module ibuffer_warp_fifo
    import ibuffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int NUM_DECODE = 2,
    parameter int BUNDLE_W   = BUNDLE_W_DEF,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1,
    localparam int EW        = BUNDLE_W + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_DECODE-1:0]            i_wr_en,
    input  logic [NUM_DECODE-1:0][EW-1:0]    i_wr_data,
    input  logic                             i_pop,
    input  logic                             i_clear,
    input  logic                             i_flush,
    output logic [EW-1:0]                    o_head,
    output logic [CW-1:0]                    o_count,
    output logic                             o_empty,
    output logic                             o_ovf
);

    logic [EW-1:0]                 r_mem [DEPTH];
    logic [PW-1:0]                 r_rd;
    logic [PW-1:0]                 r_wr;
    logic [CW-1:0]                 r_count;
    logic [NUM_DECODE-1:0]         w_acc;
    logic [NUM_DECODE-1:0][PW-1:0] w_idx;
    logic [CW-1:0]                 w_nacc;

    // Slots are accepted in index order; capacity is judged on the registered
    // count only, so a same-cycle pop never makes room for a write.
    always_comb begin
        w_acc  = '0;
        w_idx  = '0;
        w_nacc = '0;
        o_ovf  = 1'b0;
        for (int k = 0; k < NUM_DECODE; k++) begin
            w_idx[k] = r_wr + PW'(w_nacc);
            if (i_wr_en[k] && !i_flush && !i_clear) begin
                if (r_count + w_nacc < CW'(DEPTH)) begin
                    w_acc[k] = 1'b1;
                    w_nacc   = w_nacc + CW'(1);
                end else begin
                    o_ovf = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush || i_clear) begin
            r_rd    <= r_wr;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + PW'(w_nacc);
            r_rd    <= r_rd + PW'(i_pop);
            r_count <= r_count + w_nacc - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_DECODE; k++)
            if (w_acc[k]) r_mem[w_idx[k]] <= i_wr_data[k];
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/ibuffer_rr_issue.sv
// ibuffer_rr_issue: per-warp instruction buffers with round-robin issue and
// lowest-index exit sequencing.
//   Decode side : Valid/WarpID/Bundle/Exit_ID_IB (NUM_DECODE slots), Req_IB_IF
//   Control     : Flush_SIMT_IB, Ready_Scb_IB, Empty_Scb_IB, OC_Full_IB
//   Issue       : Valid/WarpID/Bundle_IB_OC (registered)
//   Exit        : Exit_IB_RAU_TM pulse, Exit_WarpID_IB_RAU_TM (held)
//   Status      : Empty_IB per warp, Overflow_IB sticky
module ibuffer_rr_issue
    import ibuffer_pkg::*;
#(
    parameter int NUM_WARPS    = 8,
    parameter int DEPTH        = 4,
    parameter int NUM_DECODE   = 2,
    parameter int BUNDLE_W     = BUNDLE_W_DEF,
    parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_DECODE-1:0]              Valid_ID_IB,
    input  logic [NUM_DECODE*LOGNUM_WARPS-1:0] WarpID_ID_IB,
    input  logic [NUM_DECODE*BUNDLE_W-1:0]     Bundle_ID_IB,
    input  logic [NUM_DECODE-1:0]              Exit_ID_IB,
    output logic [NUM_WARPS-1:0]               Req_IB_IF,
    input  logic [NUM_WARPS-1:0]               Flush_SIMT_IB,
    input  logic [NUM_WARPS-1:0]               Ready_Scb_IB,
    input  logic [NUM_WARPS-1:0]               Empty_Scb_IB,
    input  logic                               OC_Full_IB,
    output logic                               Valid_IB_OC,
    output logic [LOGNUM_WARPS-1:0]            WarpID_IB_OC,
    output logic [BUNDLE_W-1:0]                Bundle_IB_OC,
    output logic                               Exit_IB_RAU_TM,
    output logic [LOGNUM_WARPS-1:0]            Exit_WarpID_IB_RAU_TM,
    output logic [NUM_WARPS-1:0]               Empty_IB,
    output logic                               Overflow_IB
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = BUNDLE_W + 1;

    logic [NUM_DECODE-1:0][EW-1:0]             w_slot_data;
    logic [NUM_WARPS-1:0][NUM_DECODE-1:0]      w_wr_en;
    logic [NUM_WARPS-1:0][EW-1:0]              w_head;
    logic [NUM_WARPS-1:0][CW-1:0]              w_count;
    logic [NUM_WARPS-1:0]                      w_empty;
    logic [NUM_WARPS-1:0]                      w_ovf;
    logic [NUM_WARPS-1:0]                      w_pop;
    logic [NUM_WARPS-1:0]                      w_clear;
    logic [NUM_WARPS-1:0]                      w_iss_elig;
    logic [NUM_WARPS-1:0]                      w_exit_elig;
    logic [LOGNUM_WARPS-1:0]                   r_last;
    logic [LOGNUM_WARPS-1:0]                   w_cand;
    logic [LOGNUM_WARPS-1:0]                   w_gnt_id;
    logic [LOGNUM_WARPS-1:0]                   w_exit_id;
    logic                                      w_gnt;
    logic                                      w_exit;

    // Slot-to-warp decode
    always_comb begin
        w_slot_data = '0;
        w_wr_en     = '0;
        for (int k = 0; k < NUM_DECODE; k++) begin
            w_slot_data[k] = {Exit_ID_IB[k], Bundle_ID_IB[k*BUNDLE_W +: BUNDLE_W]};
            for (int w = 0; w < NUM_WARPS; w++)
                w_wr_en[w][k] = Valid_ID_IB[k] &&
                    (WarpID_ID_IB[k*LOGNUM_WARPS +: LOGNUM_WARPS] == LOGNUM_WARPS'(w));
        end
    end

    // Exit-marked heads never issue; they wait for the scoreboard to drain.
    always_comb begin
        w_iss_elig  = '0;
        w_exit_elig = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_iss_elig[w]  = !w_empty[w] && !w_head[w][BUNDLE_W] && Ready_Scb_IB[w] &&
                             !Flush_SIMT_IB[w] && !OC_Full_IB;
            w_exit_elig[w] = !w_empty[w] && w_head[w][BUNDLE_W] && Empty_Scb_IB[w] &&
                             !Flush_SIMT_IB[w];
        end
    end

    // Round-robin from last_grant+1; i == NUM_WARPS wraps back to last_grant itself.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = r_last;
        w_cand   = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            w_cand = r_last + LOGNUM_WARPS'(i);
            if (!w_gnt && w_iss_elig[w_cand]) begin
                w_gnt    = 1'b1;
                w_gnt_id = w_cand;
            end
        end
    end

    // Lowest-index exit: scan downward so the last hit is the smallest index.
    always_comb begin
        w_exit    = 1'b0;
        w_exit_id = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (w_exit_elig[i]) begin
                w_exit    = 1'b1;
                w_exit_id = LOGNUM_WARPS'(i);
            end
        end
    end

    always_comb begin
        w_pop     = '0;
        w_clear   = '0;
        Req_IB_IF = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_pop[w]     = w_gnt && (w_gnt_id == LOGNUM_WARPS'(w));
            w_clear[w]   = w_exit && (w_exit_id == LOGNUM_WARPS'(w));
            Req_IB_IF[w] = (CW'(DEPTH) - w_count[w]) >= CW'(NUM_DECODE);
        end
    end

    assign Empty_IB = w_empty;

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
        ibuffer_warp_fifo #(
            .DEPTH      (DEPTH),
            .NUM_DECODE (NUM_DECODE),
            .BUNDLE_W   (BUNDLE_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_data (w_slot_data),
            .i_pop     (w_pop[g]),
            .i_clear   (w_clear[g]),
            .i_flush   (Flush_SIMT_IB[g]),
            .o_head    (w_head[g]),
            .o_count   (w_count[g]),
            .o_empty   (w_empty[g]),
            .o_ovf     (w_ovf[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last                <= LOGNUM_WARPS'(NUM_WARPS - 1);
            Valid_IB_OC           <= 1'b0;
            WarpID_IB_OC          <= '0;
            Bundle_IB_OC          <= '0;
            Exit_IB_RAU_TM        <= 1'b0;
            Exit_WarpID_IB_RAU_TM <= '0;
            Overflow_IB           <= 1'b0;
        end else begin
            Valid_IB_OC    <= w_gnt;
            Exit_IB_RAU_TM <= w_exit;
            Overflow_IB    <= Overflow_IB | (|w_ovf);
            if (w_gnt) begin
                r_last       <= w_gnt_id;
                WarpID_IB_OC <= w_gnt_id;
                Bundle_IB_OC <= w_head[w_gnt_id][BUNDLE_W-1:0];
            end
            if (w_exit) Exit_WarpID_IB_RAU_TM <= w_exit_id;
        end
    end

endmodule
